// File: rtl/wb_split_pkg.sv
// wb_split_pkg: shared state encoding, fault codes and sizing helper for the Wishbone splitter.
package wb_split_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_UNMAPPED = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_split_decode.sv
// wb_split_decode: maps the selected address field to a slave hit flag and slave index.
module wb_split_decode
   import wb_split_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_MSB    = 19,
   parameter int SEL_LSB    = 16,
   parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_IDS = {4'd6, 4'd4, 4'd2, 4'd0},
   localparam int W  = SEL_MSB - SEL_LSB + 1,
   localparam int IW = idx_width(NUM_SLAVES)
) (
   input  logic [SEL_MSB:SEL_LSB] field_i,
   output logic                   hit_o,
   output logic [IW-1:0]          idx_o
);

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (field_i == SLAVE_IDS[i*W +: W]) begin
            hit_o = 1'b1;
            idx_o = IW'(i);
         end
   end

endmodule

// File: rtl/wb_split_n.sv
// wb_split_n: Wishbone classic splitter steering one master to NUM_SLAVES slaves,
// with per-transaction ack timeout, unmapped-address error response and sticky fault record.
module wb_split_n
   import wb_split_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_MSB    = 19,
   parameter int SEL_LSB    = 16,
   parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_IDS = {4'd6, 4'd4, 4'd2, 4'd0},
   parameter int TIMEOUT    = 255,
   parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_ni,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   output logic                     s_cyc_o,
   output logic                     s_we_o,
   output logic [3:0]               s_sel_o,
   output logic [31:0]              s_adr_o,
   output logic [31:0]              s_dat_o,
   output logic [NUM_SLAVES-1:0]    s_stb_o,
   input  logic [NUM_SLAVES-1:0]    s_ack_i,
   input  logic [NUM_SLAVES*32-1:0] s_dat_i,
   input  logic                     fault_clr_i,
   output logic                     fault_o,
   output logic [1:0]               fault_code_o,
   output logic [31:0]              fault_adr_o
);

   localparam int IW = idx_width(NUM_SLAVES);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic          fault_q, fault_d;
   logic [1:0]    code_q, code_d;
   logic [31:0]   fadr_q, fadr_d;
   logic          hit, fault_ev;
   logic [IW-1:0] hit_idx;
   logic [1:0]    ev_code;

   wb_split_decode #(
      .NUM_SLAVES(NUM_SLAVES),
      .SEL_MSB   (SEL_MSB),
      .SEL_LSB   (SEL_LSB),
      .SLAVE_IDS (SLAVE_IDS)
   ) u_decode (
      .field_i(wbs_adr_i[SEL_MSB:SEL_LSB]),
      .hit_o  (hit),
      .idx_o  (hit_idx)
   );

   assign s_cyc_o      = wbs_cyc_i;
   assign s_we_o       = wbs_we_i;
   assign s_sel_o      = wbs_sel_i;
   assign s_adr_o      = wbs_adr_i;
   assign s_dat_o      = wbs_dat_i;
   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign fault_o      = fault_q;
   assign fault_code_o = code_q;
   assign fault_adr_o  = fadr_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      dat_d    = dat_q;
      ack_d    = 1'b0;
      fault_ev = 1'b0;
      ev_code  = FAULT_NONE;
      s_stb_o  = '0;
      case (state_q)
         IDLE:
            if (wbs_cyc_i && wbs_stb_i) begin
               if (hit) begin
                  idx_d   = hit_idx;
                  cnt_d   = '0;
                  state_d = WAIT;
               end else begin
                  dat_d    = DEFAULT_DATA;
                  ack_d    = 1'b1;
                  fault_ev = 1'b1;
                  ev_code  = FAULT_UNMAPPED;
                  state_d  = RESP;
               end
            end
         WAIT: begin
            s_stb_o[idx_q] = wbs_cyc_i & wbs_stb_i;
            cnt_d          = cnt_q + 16'd1;
            if (s_ack_i[idx_q]) begin
               dat_d   = s_dat_i[32*idx_q +: 32];
               ack_d   = 1'b1;
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               dat_d    = DEFAULT_DATA;
               ack_d    = 1'b1;
               fault_ev = 1'b1;
               ev_code  = FAULT_TIMEOUT;
               state_d  = RESP;
            end else if (!wbs_cyc_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      fault_d = fault_clr_i ? 1'b0 : fault_q;
      code_d  = fault_clr_i ? FAULT_NONE : code_q;
      fadr_d  = fault_clr_i ? '0 : fadr_q;
      // A clear in the same cycle as a new fault lets the new fault through
      if (fault_ev && (!fault_q || fault_clr_i)) begin
         fault_d = 1'b1;
         code_d  = ev_code;
         fadr_d  = wbs_adr_i;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= FAULT_NONE;
         fadr_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         fadr_q  <= fadr_d;
      end
   end

endmodule

// File: tb/tb_wb_split_n.sv
// tb_wb_split_n: directed and randomized checks of wb_split_n against a transaction-level model.
module tb_wb_split_n;
   import wb_split_pkg::*;

   localparam int NS = 4;
   localparam int TO = 8;
   localparam logic [31:0] DEF = 32'hDEADBEEF;

   logic             clk = 1'b0, rst_n = 1'b1;
   logic             cyc = 1'b0, stb = 1'b0, we = 1'b0, clr = 1'b0;
   logic [3:0]       sel = '0;
   logic [31:0]      adr = '0, wdat = '0;
   logic [NS-1:0]    s_ack = '0;
   logic [NS*32-1:0] s_dat = '0;
   logic             ack_o, s_cyc, s_we, fault;
   logic [31:0]      dat_o, s_adr, s_wdat, fadr;
   logic [3:0]       s_sel;
   logic [NS-1:0]    s_stb;
   logic [1:0]       fcode;

   int tests = 0, fails = 0;
   int ids[NS] = '{0, 2, 4, 6};
   logic        m_fault = 1'b0;
   logic [1:0]  m_code = 2'b00;
   logic [31:0] m_adr = '0;
   int          obs_lat, obs_acks, idle_acks;
   logic [31:0] obs_dat;
   logic [NS-1:0] obs_stb[32];

   wb_split_n #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
      .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
      .s_stb_o(s_stb), .s_ack_i(s_ack), .s_dat_i(s_dat),
      .fault_clr_i(clr), .fault_o(fault), .fault_code_o(fcode), .fault_adr_o(fadr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Transaction-level prediction: decode by ID lookup, latency from ack cycle vs timeout
   function automatic void predict(input logic [31:0] a, input int k,
                                   output int tgt, output int lat, output logic [1:0] code);
      tgt = -1;
      for (int i = 0; i < NS; i++) if (int'(a[19:16]) == ids[i]) tgt = i;
      if (tgt < 0) begin lat = 1; code = 2'b01; end
      else if (k <= TO) begin lat = k + 1; code = 2'b00; end
      else begin lat = TO + 1; code = 2'b10; end
   endfunction

   function automatic void model_fault(input logic [1:0] code, input logic [31:0] a, input bit c);
      if (c) begin m_fault = 1'b0; m_code = 2'b00; m_adr = '0; end
      if (code != 2'b00 && !m_fault) begin m_fault = 1'b1; m_code = code; m_adr = a; end
   endfunction

   task automatic drive(input logic [31:0] a, input logic w, input int k, input int tgt,
                        input logic [31:0] sdat, input bit clr0, input int abort_at);
      logic [NS-1:0] oh;
      oh = (tgt >= 0) ? NS'(1) << tgt : '0;
      obs_lat = -1;
      obs_acks = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = 4'($urandom); wdat = $urandom; clr = clr0;
      for (int c = 0; c <= TO + 4 && obs_lat < 0; c++) begin
         if (c > 0) begin @(negedge clk); clr = 1'b0; end
         if (c == abort_at) begin cyc = 1'b0; stb = 1'b0; end
         s_ack = (NS'($urandom) & ~oh) | ((c == k) ? oh : '0);
         s_dat = {$urandom, $urandom, $urandom, $urandom};
         if (tgt >= 0) s_dat[32*tgt +: 32] = sdat;
         #1;
         obs_stb[c] = s_stb;
         if (ack_o) begin
            obs_acks++;
            if (obs_lat < 0) begin obs_lat = c; obs_dat = dat_o; end
         end
      end
   endtask

   task automatic idle(input int n, input bit c0);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         cyc = 1'b0; stb = 1'b0; clr = c0 && c == 0; s_ack = NS'($urandom);
         #1;
         if (ack_o) idle_acks++;
      end
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({ack_o, dat_o, s_stb, fault, fcode, fadr} !== '0) begin
         fails++;
         $display("FAIL reset_state: ack=%b dat=%h stb=%b fault=%b code=%b adr=%h, want all 0",
                  ack_o, dat_o, s_stb, fault, fcode, fadr);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mapped_read;
      bit bad = 0;
      drive(32'h3004_0004, 1'b0, 4, 2, 32'h1234_5678, 1'b0, -1);
      tests++;
      if (obs_lat != 5 || obs_acks != 1) begin
         fails++; $display("FAIL mapped_latency: got %0d acks=%0d, want 5 acks=1", obs_lat, obs_acks);
      end
      tests++;
      if (obs_dat !== 32'h1234_5678) begin
         fails++; $display("FAIL mapped_data: got %h want 12345678", obs_dat);
      end
      for (int c = 0; c <= 5; c++) if (obs_stb[c] !== ((c >= 1 && c <= 4) ? 4'b0100 : 4'b0000)) bad = 1;
      tests++;
      if (bad) begin fails++; $display("FAIL mapped_stb: stb pattern not 0100 only in cycles 1..4"); end
      tests++;
      if ({s_cyc, s_we, s_sel, s_adr, s_wdat} !== {1'b1, 1'b0, sel, 32'h3004_0004, wdat}) begin
         fails++; $display("FAIL fanout: got adr=%h sel=%h dat=%h, want adr=30040004 sel=%h dat=%h",
                           s_adr, s_sel, s_wdat, sel, wdat);
      end
      idle_acks = 0;
      idle(1, 1'b0);
      tests++;
      if (idle_acks != 0 || fault !== 1'b0) begin
         fails++; $display("FAIL mapped_single_ack: idle_acks=%0d fault=%b, want 0 and 0", idle_acks, fault);
      end
   endtask

   task automatic test_unmapped;
      drive(32'h300F_0000, 1'b0, 100, -1, 32'h0, 1'b0, -1);
      model_fault(2'b01, 32'h300F_0000, 1'b0);
      tests++;
      if (obs_lat != 1 || obs_dat !== DEF || obs_stb[0] !== '0 || obs_stb[1] !== '0) begin
         fails++; $display("FAIL unmapped_resp: lat=%0d dat=%h, want lat 1 dat deadbeef no stb", obs_lat, obs_dat);
      end
      tests++;
      if ({fault, fcode, fadr} !== {1'b1, 2'b01, 32'h300F_0000}) begin
         fails++; $display("FAIL unmapped_fault: got %b/%b/%h want 1/01/300f0000", fault, fcode, fadr);
      end
   endtask

   task automatic test_timeout_faults;
      drive(32'h3002_0000, 1'b0, 100, 1, 32'h0, 1'b0, -1);
      tests++;
      if (obs_lat != TO + 1 || obs_dat !== DEF || obs_stb[TO] !== 4'b0010 || obs_stb[TO+1] !== '0) begin
         fails++; $display("FAIL timeout_resp: lat=%0d dat=%h, want lat %0d dat deadbeef", obs_lat, obs_dat, TO + 1);
      end
      tests++;
      if ({fault, fcode, fadr} !== {1'b1, 2'b01, 32'h300F_0000}) begin
         fails++; $display("FAIL first_fault_wins: got %b/%b/%h want 1/01/300f0000", fault, fcode, fadr);
      end
      idle(1, 1'b1);
      idle(1, 1'b0);
      tests++;
      if ({fault, fcode, fadr} !== '0) begin
         fails++; $display("FAIL fault_clear: got %b/%b/%h want all 0", fault, fcode, fadr);
      end
      drive(32'h3002_0040, 1'b1, 100, 1, 32'h0, 1'b0, -1);
      tests++;
      if ({fault, fcode, fadr} !== {1'b1, 2'b10, 32'h3002_0040} || obs_lat != TO + 1) begin
         fails++; $display("FAIL timeout_fault: got %b/%b/%h lat=%0d want 1/10/30020040 lat %0d",
                           fault, fcode, fadr, obs_lat, TO + 1);
      end
      idle(1, 1'b0);
      drive(32'h3009_0000, 1'b0, 100, -1, 32'h0, 1'b1, -1);
      tests++;
      if ({fault, fcode, fadr} !== {1'b1, 2'b01, 32'h3009_0000}) begin
         fails++; $display("FAIL clear_with_new_fault: got %b/%b/%h want 1/01/30090000", fault, fcode, fadr);
      end
      idle(1, 1'b0);
   endtask

   task automatic test_abort;
      drive(32'h3006_0000, 1'b0, 100, 3, 32'h0, 1'b0, 3);
      tests++;
      if (obs_lat != -1 || obs_stb[1] !== 4'b1000 || obs_stb[3] !== '0 || obs_stb[4] !== '0) begin
         fails++; $display("FAIL abort: lat=%0d stb1=%b stb3=%b stb4=%b, want no ack 1000 0000 0000",
                           obs_lat, obs_stb[1], obs_stb[3], obs_stb[4]);
      end
      tests++;
      if ({fault, fcode, fadr} !== {1'b1, 2'b01, 32'h3009_0000}) begin
         fails++; $display("FAIL abort_fault: got %b/%b/%h want 1/01/30090000", fault, fcode, fadr);
      end
      drive(32'h3000_0020, 1'b0, 2, 0, 32'hCAFE_0001, 1'b0, -1);
      tests++;
      if (obs_lat != 3 || obs_dat !== 32'hCAFE_0001) begin
         fails++; $display("FAIL after_abort: lat=%0d dat=%h want 3 cafe0001", obs_lat, obs_dat);
      end
   endtask

   task automatic test_back_to_back;
      drive(32'h3000_0100, 1'b0, 1, 0, 32'hA5A5_0000, 1'b0, -1);
      tests++;
      if (obs_lat != 2 || obs_dat !== 32'hA5A5_0000) begin
         fails++; $display("FAIL b2b_first: lat=%0d dat=%h want 2 a5a50000", obs_lat, obs_dat);
      end
      drive(32'h3006_0200, 1'b0, 1, 3, 32'h5A5A_0003, 1'b0, -1);
      tests++;
      if (obs_lat != 2 || obs_acks != 1 || obs_dat !== 32'h5A5A_0003) begin
         fails++; $display("FAIL b2b_second: lat=%0d acks=%0d dat=%h want 2 1 5a5a0003", obs_lat, obs_acks, obs_dat);
      end
      idle(1, 1'b0);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0010; s_ack = '0;
      @(negedge clk);
      #1;
      tests++;
      if (s_stb !== 4'b0001) begin fails++; $display("FAIL reset_mid_stb: got %b want 0001", s_stb); end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({ack_o, dat_o, s_stb, fault, fcode, fadr} !== '0) begin
         fails++; $display("FAIL reset_mid: ack=%b dat=%h stb=%b fault=%b, want all 0", ack_o, dat_o, s_stb, fault);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_fault = 1'b0; m_code = 2'b00; m_adr = '0;
      idle_acks = 0;
      idle(4, 1'b0);
      tests++;
      if (idle_acks != 0) begin fails++; $display("FAIL stray_ack: got %0d acks want 0", idle_acks); end
   endtask

   task automatic test_random;
      int tgt, lat, k, gap, f;
      logic [1:0] code;
      logic [31:0] a, sdat;
      logic w;
      bit c0, ci, bad;
      logic [NS-1:0] oh;
      idle_acks = 0;
      for (int n = 0; n < 60; n++) begin
         gap = $urandom_range(0, 2);
         ci = ($urandom_range(0, 4) == 0);
         if (gap > 0) begin idle(gap, ci); if (ci) model_fault(2'b00, '0, 1'b1); end
         f = ($urandom_range(0, 3) != 0) ? ids[$urandom_range(0, NS - 1)] : 2 * $urandom_range(0, 7) + 1;
         a = $urandom;
         a[19:16] = f[3:0];
         k = $urandom_range(1, TO + 2);
         w = 1'($urandom);
         sdat = $urandom;
         c0 = ($urandom_range(0, 7) == 0);
         predict(a, k, tgt, lat, code);
         drive(a, w, k, tgt, sdat, c0, -1);
         model_fault(code, a, c0);
         tests++;
         if (obs_lat != lat || obs_acks != 1) begin
            fails++; $display("FAIL rand_latency[%0d]: adr=%h k=%0d got %0d acks=%0d want %0d", n, a, k, obs_lat, obs_acks, lat);
         end
         if (!w) begin
            tests++;
            if (obs_dat !== ((code == 2'b00) ? sdat : DEF)) begin
               fails++; $display("FAIL rand_data[%0d]: got %h want %h", n, obs_dat, (code == 2'b00) ? sdat : DEF);
            end
         end
         oh = (tgt >= 0) ? NS'(1) << tgt : '0;
         bad = 0;
         for (int c = 0; c <= lat; c++) if (obs_stb[c] !== ((c >= 1 && c < lat) ? oh : '0)) bad = 1;
         tests++;
         if (bad) begin fails++; $display("FAIL rand_stb[%0d]: adr=%h wrong strobe pattern", n, a); end
         tests++;
         if ({fault, fcode, fadr} !== {m_fault, m_code, m_adr}) begin
            fails++; $display("FAIL rand_fault[%0d]: got %b/%b/%h want %b/%b/%h", n, fault, fcode, fadr, m_fault, m_code, m_adr);
         end
      end
      idle(2, 1'b0);
      tests++;
      if (idle_acks != 0) begin fails++; $display("FAIL rand_idle_ack: got %0d want 0", idle_acks); end
   endtask

   initial begin
      test_reset();
      test_mapped_read();
      test_unmapped();
      test_timeout_faults();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
